// File: rtl/fir_mac_sched.sv
// fir_mac_sched: I/Q time-multiplexed tap/accumulator scheduler for a shared-DSP RRC FIR.
// Define GDSP_FIR_FOLD_EN to enable symmetric-coefficient folding (pre-add of mirrored taps).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a sample pair, in_ready high
// S_SHIFT   | one-cycle delay-line shift strobe
// S_ISSUE_I | issuing tap indices 0..M-1 for the I channel
// S_ISSUE_Q | issuing tap indices 0..M-1 for the Q channel
// S_DRAIN   | waiting for the last Q product to clear the MAC pipeline
module fir_mac_sched #(
  parameter int NUM_TAPS = 9,
  parameter int MAC_LAT  = 2,
  parameter int TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic [TAP_W-1:0] tap_idx,
  output logic [TAP_W-1:0] tap_idx_b,
  output logic             pre_add,
  output logic             ch_sel,
  output logic             acc_en,
  output logic             acc_load,
  output logic             cap_i,
  output logic             cap_q,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

`ifdef GDSP_FIR_FOLD_EN
  localparam int M = (NUM_TAPS + 1) / 2;
  localparam logic [TAP_W-1:0] CENTRE = TAP_W'((NUM_TAPS - 1) / 2);
  localparam bit ODD = (NUM_TAPS % 2) == 1;
`else
  localparam int M = NUM_TAPS;
`endif
  localparam logic [TAP_W-1:0] LAST_IDX = TAP_W'(M - 1);
  localparam logic [TAP_W-1:0] MIRROR   = TAP_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_ISSUE_I,
    S_ISSUE_Q,
    S_DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [TAP_W-1:0] cnt, cnt_nxt;
  logic             issue, issue_ch, issue_first, issue_last_q;
  logic             cap_q_r, out_valid_r, overrun_r;
  logic [3:0]       pipe_in, pipe_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    shift_en  = 1'b0;
    issue     = 1'b0;
    issue_ch  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en  = 1'b1;
        state_nxt = S_ISSUE_I;
      end
      S_ISSUE_I: begin
        issue = 1'b1;
        if (cnt == LAST_IDX) state_nxt = S_ISSUE_Q;
        else                 cnt_nxt   = cnt + TAP_W'(1);
      end
      S_ISSUE_Q: begin
        issue    = 1'b1;
        issue_ch = 1'b1;
        if (cnt == LAST_IDX) state_nxt = S_DRAIN;
        else                 cnt_nxt   = cnt + TAP_W'(1);
      end
      S_DRAIN: begin
        if (cap_q_r) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // cnt is held at zero outside the issue window, so the address outputs rest at 0
  assign issue_first  = issue && (cnt == '0);
  assign issue_last_q = issue && issue_ch && (cnt == LAST_IDX);
  assign tap_idx      = cnt;
  assign tap_idx_b    = MIRROR - cnt;
  assign ch_sel       = issue_ch;

`ifdef GDSP_FIR_FOLD_EN
  assign pre_add = issue && !(ODD && (cnt == CENTRE));
`else
  assign pre_add = 1'b0;
`endif

  // Control tags travel alongside the product through the multiplier pipeline
  assign pipe_in = {issue, issue_first, issue_ch, issue_last_q};

  generate
    if (MAC_LAT == 0) begin : g_nolat
      assign pipe_out = pipe_in;
    end else begin : g_lat
      logic [3:0] dly [MAC_LAT];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < MAC_LAT; i++) dly[i] <= '0;
        end else begin
          dly[0] <= pipe_in;
          for (int i = 1; i < MAC_LAT; i++) dly[i] <= dly[i-1];
        end
      end
      assign pipe_out = dly[MAC_LAT-1];
    end
  endgenerate

  assign acc_en   = pipe_out[3];
  assign acc_load = pipe_out[2];
  // I result is complete exactly when the first Q product loads the accumulator
  assign cap_i    = pipe_out[2] & pipe_out[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q_r     <= 1'b0;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      cap_q_r     <= pipe_out[0];
      out_valid_r <= cap_q_r;
      if (in_valid && !in_ready) overrun_r <= 1'b1;
      else if (clr_ovr)          overrun_r <= 1'b0;
    end
  end

  assign cap_q     = cap_q_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched: timing model, vector table, corner sequences and MAC/FIR check.
module tb_fir_mac_sched;
  localparam int N = 9;
  localparam int L = 2;
`ifdef GDSP_FIR_FOLD_EN
  localparam int M = (N + 1) / 2;
  localparam bit FOLD = 1'b1;
`else
  localparam int M = N;
  localparam bit FOLD = 1'b0;
`endif
  localparam int TW  = $clog2(N);
  localparam int PER = 3 + L + 2 * M;

  logic clk = 1'b0;
  logic rst_n, in_valid, clr_ovr;
  logic in_ready, shift_en, pre_add, ch_sel, acc_en, acc_load, cap_i, cap_q, out_valid, busy, overrun;
  logic [TW-1:0] tap_idx, tap_idx_b;

  logic iv2, clr2;
  logic rdy2, sh2, pa2, ch2, ae2, al2, ci2, cq2, ov2, busy2, ovr2;
  logic [0:0] ti2, tib2;

  always #5 clk = ~clk;

  fir_mac_sched #(.NUM_TAPS(N), .MAC_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .shift_en(shift_en),
    .tap_idx(tap_idx), .tap_idx_b(tap_idx_b), .pre_add(pre_add), .ch_sel(ch_sel),
    .acc_en(acc_en), .acc_load(acc_load), .cap_i(cap_i), .cap_q(cap_q), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  fir_mac_sched #(.NUM_TAPS(1), .MAC_LAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2), .shift_en(sh2),
    .tap_idx(ti2), .tap_idx_b(tib2), .pre_add(pa2), .ch_sel(ch2),
    .acc_en(ae2), .acc_load(al2), .cap_i(ci2), .cap_q(cq2), .out_valid(ov2),
    .busy(busy2), .overrun(ovr2), .clr_ovr(clr2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic drive_at(input int c);
    at_neg(c - 1);
    @(posedge clk);
    #1;
  endtask

  // Cycle-level expectation derived from the accept time of the current run
  bit run_chk = 1'b0;
  int ta = 0;
  bit ta_ok = 1'b0;
  bit exp_ovr = 1'b0;
  always @(negedge clk) begin
    int d, k;
    bit act, iss, ch, e_acc, e_load, e_pre;
    logic [2*TW+10:0] ev, av;
    if (run_chk) begin
      d      = cyc - ta;
      act    = ta_ok && (d < PER);
      iss    = act && (d >= 2) && (d <= 1 + 2 * M);
      k      = iss ? (d - 2) % M : 0;
      ch     = iss && ((d - 2) >= M);
      e_acc  = act && (d >= 2 + L) && (d <= 1 + L + 2 * M);
      e_load = e_acc && (((d - 2 - L) % M) == 0);
      e_pre  = FOLD && iss && !((N % 2 == 1) && (k == (N - 1) / 2));
      ev = {!act, act, act && (d == 1), TW'(k), TW'(N - 1 - k), e_pre, ch, e_acc, e_load,
            act && (d == 2 + L + M), act && (d == 2 + L + 2 * M), ta_ok && (d == PER), exp_ovr};
      av = {in_ready, busy, shift_en, tap_idx, tap_idx_b, pre_add, ch_sel, acc_en, acc_load,
            cap_i, cap_q, out_valid, overrun};
      check("cycle_model", 32'(av), 32'(ev));
      if (!rst_n) begin
        ta_ok   = 1'b0;
        exp_ovr = 1'b0;
      end else begin
        if (in_valid && act)  exp_ovr = 1'b1;
        else if (clr_ovr)     exp_ovr = 1'b0;
        if (in_valid && !act) begin
          ta    = cyc;
          ta_ok = 1'b1;
        end
      end
    end
  end

  // Datapath emulation: delay lines, coefficient ROM, pipelined multiplier and accumulator
  int coef [N];
  int xi [N];
  int xq [N];
  int pp [8];
  int pend_i = 0, pend_q = 0, cur_i = 0, cur_q = 0;
  int acc = 0, cap_iv = 0, cap_qv = 0;
  int n_out = 0;
  always @(negedge clk) begin
    int a, b, s, pn, pa, ei, eq;
    if (run_chk) begin
      a = int'(tap_idx);
      b = int'(tap_idx_b);
      s = 0;
      if (a < N) s = ch_sel ? xq[a] : xi[a];
      if (pre_add && b < N) s = s + (ch_sel ? xq[b] : xi[b]);
      pn = (a < N) ? coef[a] * s : 0;
      pa = pp[L-1];
      for (int i = 7; i > 0; i--) pp[i] = pp[i-1];
      pp[0] = pn;
      if (cap_i) cap_iv = acc;
      if (cap_q) cap_qv = acc;
      if (acc_en) acc = acc_load ? pa : acc + pa;
      if (out_valid) begin
        ei = 0;
        eq = 0;
        for (int n = 0; n < N; n++) begin
          ei += coef[n] * xi[n];
          eq += coef[n] * xq[n];
        end
        check("fir_i", cap_iv, ei);
        check("fir_q", cap_qv, eq);
        n_out++;
      end
      if (shift_en) begin
        for (int n = N - 1; n > 0; n--) begin
          xi[n] = xi[n-1];
          xq[n] = xq[n-1];
        end
        xi[0] = pend_i;
        xq[0] = pend_q;
      end
      if (in_valid && in_ready && rst_n) begin
        pend_i = cur_i;
        pend_q = cur_q;
        cur_i  = int'($urandom_range(0, 255)) - 128;
        cur_q  = int'($urandom_range(0, 255)) - 128;
      end
    end
  end

  typedef struct {
    int off;
    int tap;
    bit ch, sh, ld, ci, cq, ov, rdy;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [12];
    int accepts [$];
    int base, limit;
    bit seen;
    logic [7:0] exp2 [6];

    rst_n = 1'b0; in_valid = 1'b0; clr_ovr = 1'b0; iv2 = 1'b0; clr2 = 1'b0;
    for (int n = 0; n < N; n++) begin
      coef[n] = int'($urandom_range(0, 255)) - 128;
      xi[n] = 0;
      xq[n] = 0;
    end
    if (FOLD) for (int n = 0; n < N; n++) if (n > (N - 1) / 2) coef[n] = coef[N - 1 - n];
    for (int i = 0; i < 8; i++) pp[i] = 0;
    cur_i = int'($urandom_range(0, 255)) - 128;
    cur_q = int'($urandom_range(0, 255)) - 128;

    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    run_chk = 1'b1;

    at_neg(4);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tap_idx", tap_idx, 0);
    check("rst_tap_idx_b", tap_idx_b, N - 1);
    check("rst_outs", {shift_en, acc_en, acc_load, cap_i, cap_q, out_valid, overrun, pre_add}, 0);

    // Single pulse at T = 10
    tv[0]  = '{0,           0,     0, 0, 0, 0, 0, 0, 1};
    tv[1]  = '{1,           0,     0, 1, 0, 0, 0, 0, 0};
    tv[2]  = '{2,           0,     0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{2 + L,       L,     0, 0, 1, 0, 0, 0, 0};
    tv[4]  = '{1 + M,       M - 1, 0, 0, 0, 0, 0, 0, 0};
    tv[5]  = '{2 + M,       0,     1, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{2 + L + M,   L,     1, 0, 1, 1, 0, 0, 0};
    tv[7]  = '{1 + 2 * M,   M - 1, 1, 0, 0, 0, 0, 0, 0};
    tv[8]  = '{2 + 2 * M,   0,     0, 0, 0, 0, 0, 0, 0};
    tv[9]  = '{2 + L + 2*M, 0,     0, 0, 0, 0, 1, 0, 0};
    tv[10] = '{3 + L + 2*M, 0,     0, 0, 0, 0, 0, 1, 1};
    tv[11] = '{4 + L + 2*M, 0,     0, 0, 0, 0, 0, 0, 1};
    drive_at(10);
    in_valid = 1'b1;
    fork
      begin
        drive_at(11);
        in_valid = 1'b0;
      end
    join_none
    for (int i = 0; i < 12; i++) begin
      at_neg(10 + tv[i].off);
      check($sformatf("vec%0d_T+%0d", i, tv[i].off),
            32'({tap_idx, ch_sel, shift_en, acc_load, cap_i, cap_q, out_valid, in_ready}),
            32'({TW'(tv[i].tap), tv[i].ch, tv[i].sh, tv[i].ld, tv[i].ci, tv[i].cq, tv[i].ov, tv[i].rdy}));
    end

    // in_valid held high for 100 cycles, clr_ovr pulsed while busy
    drive_at(60);
    in_valid = 1'b1;
    for (int c = 60; c < 160; c++) begin
      at_neg(c);
      if (in_ready) accepts.push_back(c);
      if (c == accepts[0] + 2) check("overrun_after_busy", overrun, 1);
      if (c == accepts[0] + 6) check("overrun_set_wins", overrun, 1);
      @(posedge clk);
      #1;
      clr_ovr = (c + 1 == accepts[0] + 5);
    end
    in_valid = 1'b0;
    clr_ovr  = 1'b0;
    check("held_accept_count", accepts.size(), 99 / PER + 1);
    for (int i = 1; i < accepts.size(); i++)
      check($sformatf("held_spacing%0d", i), accepts[i] - accepts[i-1], PER);

    // NUM_TAPS = 1, MAC_LAT = 0 instance
    exp2[0] = 8'b0000_0001;
    exp2[1] = 8'b1000_0000;
    exp2[2] = 8'b0110_0000;
    exp2[3] = 8'b0111_1000;
    exp2[4] = 8'b0000_0100;
    exp2[5] = 8'b0000_0011;
    drive_at(170);
    iv2 = 1'b1;
    fork
      begin
        drive_at(171);
        iv2 = 1'b0;
      end
    join_none
    for (int i = 0; i < 6; i++) begin
      at_neg(170 + i);
      check($sformatf("lat0_T+%0d", i), 32'({sh2, ae2, al2, ch2, ci2, cq2, ov2, rdy2}), 32'(exp2[i]));
    end

    // Mid-run reset at T+15
    drive_at(200);
    in_valid = 1'b1;
    drive_at(201);
    in_valid = 1'b0;
    drive_at(205);
    in_valid = 1'b1;
    drive_at(206);
    in_valid = 1'b0;
    at_neg(210);
    check("ovr_before_reset", overrun, 1);
    drive_at(215);
    rst_n = 1'b0;
    drive_at(216);
    rst_n = 1'b1;
    at_neg(216);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_acc_en", acc_en, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_overrun", overrun, 0);
    seen = 1'b0;
    for (int c = 217; c < 247; c++) begin
      at_neg(c);
      if (cap_q || out_valid) seen = 1'b1;
    end
    check("rst_mid_no_capture", seen, 0);

    // Random traffic through the MAC model until 1000 results
    base  = n_out;
    limit = cyc + 40000;
    while (n_out - base < 1000 && cyc < limit) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 1) == 1);
      clr_ovr  = ($urandom_range(0, 15) == 0);
    end
    in_valid = 1'b0;
    clr_ovr  = 1'b0;
    check("mac_sample_count", n_out - base, 1000);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
- Scheduler for a time-multiplexed RRC FIR that shares one multiplier/accumulator between the I and Q channels.
- Per accepted input sample pair it:
  - strobes the delay lines to shift,
  - walks the tap index for I, then for Q,
  - drives accumulator load/enable/capture, delayed to match the multiplier pipeline.
- Sits between the symbol mapper/upsampler and the shared MAC datapath. Replaces 2×NUM_TAPS parallel multipliers with one DSP block.

Parameters:
- NUM_TAPS, 9, filter length, 1..15.
- MAC_LAT, 2, cycles from tap_idx/ch_sel presented to product at accumulator input, 0..7.
- TAP_W, $clog2(NUM_TAPS) (min 1), tap index width (derived, do not override).

Ports:
- clk  in  1  system clock (27 MHz domain).
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  new I/Q sample pair available.
- in_ready  out  1  scheduler can accept; high only in IDLE.
- shift_en  out  1  one-cycle pulse: delay lines shift in the new pair.
- tap_idx  out  TAP_W  coefficient ROM / delay-line read index A.
- tap_idx_b  out  TAP_W  mirrored index NUM_TAPS-1-tap_idx (used only in fold mode; tracks tap_idx otherwise).
- pre_add  out  1  fold mode: add samples at tap_idx and tap_idx_b; 0 for the centre tap and when folding is off.
- ch_sel  out  1  0 = I, 1 = Q (address phase).
- acc_en  out  1  accumulator accepts product (accumulator phase).
- acc_load  out  1  with acc_en: load product instead of add (first product of a channel).
- cap_i  out  1  capture accumulator into I output register.
- cap_q  out  1  capture accumulator into Q output register.
- out_valid  out  1  one-cycle pulse: filtered I/Q pair valid.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: in_valid seen while in_ready low.
- clr_ovr  in  1  clears overrun.

Behaviour:
- Reset: all outputs 0 except in_ready = 1 (FSM in IDLE). tap_idx = 0 and tap_idx_b = NUM_TAPS-1.
- Let M = NUM_TAPS (or ceil(NUM_TAPS/2) with folding). Let T be the accept cycle (in_valid && in_ready).
- FSM transitions:
  - IDLE → SHIFT on accept.
  - SHIFT (1 cycle, shift_en = 1) → ISSUE_I.
  - ISSUE_I (M cycles, ch_sel = 0, tap_idx 0..M-1) → ISSUE_Q.
  - ISSUE_Q (M cycles, ch_sel = 1, tap_idx 0..M-1) → DRAIN.
  - DRAIN → IDLE the cycle after cap_q.
- Issue window: cycles T+2 .. T+1+2M. In this window an internal issue flag, issue-first flag (tap_idx == 0) and channel tag feed a MAC_LAT-deep shift register.
- Accumulator-phase outputs:
  - acc_en = issue flag delayed MAC_LAT.
  - acc_load = issue-first delayed MAC_LAT.
- Captures:
  - cap_i is asserted at T+2+MAC_LAT+M, the same cycle as the Q acc_load. Capture samples the pre-load accumulator value.
  - cap_q is asserted at T+2+MAC_LAT+2M.
  - out_valid is asserted at T+3+MAC_LAT+2M.
- Return to IDLE: in_ready returns high at T+3+MAC_LAT+2M. Defaults give period 23 cycles (unfolded) / 15 (folded).
- tap_idx returns to 0 on each channel start. It never exceeds M-1.
- When not issuing, outputs hold: tap_idx = 0, ch_sel = 0, pre_add = 0.
- in_valid while busy: request ignored (no queueing), overrun set.
- overrun set and clr_ovr in the same cycle: set wins.
- in_valid held high continuously: accepted on each IDLE cycle. Back-to-back runs have no gap beyond the IDLE cycle.
- Reset asserted mid-run:
  - Sequence aborts.
  - The delay shift register is cleared.
  - No cap_*/out_valid is emitted.
  - Outputs reach reset values at the next edge.
- MAC_LAT = 0: accumulator-phase signals are combinationally aligned with issue (no delay stage).

Optional Feature:
- GDSP_FIR_FOLD_EN:
  - Defined: symmetric-coefficient folding. M = ceil(NUM_TAPS/2). tap_idx_b = NUM_TAPS-1-tap_idx. pre_add = 1 for every issued index except the centre tap (tap_idx == (NUM_TAPS-1)/2 when NUM_TAPS is odd).
  - Undefined: M = NUM_TAPS, pre_add tied 0, tap_idx_b mirrors tap_idx.

Test Plan:
- Defaults, single in_valid pulse at T = 10:
  - shift_en at 11.
  - tap_idx 0..8 with ch_sel = 0 at 12..20; 0..8 with ch_sel = 1 at 21..29.
  - acc_load at 14 and 23.
  - cap_i at 23, cap_q at 32, out_valid at 33, in_ready high at 33.
- in_valid held high 100 cycles: accepts at 23-cycle spacing. overrun = 1 after the first busy cycle. clr_ovr pulse while in_valid still high keeps overrun = 1 (set wins).
- Reset (rst_n = 0 one cycle) at T+15 of a run: next cycle busy = 0, acc_en = 0, in_ready = 1, overrun = 0. No cap_q or out_valid in the following 30 cycles.
- GDSP_FIR_FOLD_EN, NUM_TAPS = 9:
  - Per channel: tap_idx 0..4, tap_idx_b 8..4, pre_add = 1,1,1,1,0.
  - out_valid at T+15.
- MAC_LAT = 0, NUM_TAPS = 1: acc_load and acc_en coincide with issue at T+2 (I) and T+3 (Q). cap_i at T+3, cap_q at T+4, out_valid at T+5.
- Accumulator model check: random taps/samples through the scheduler plus reference MAC. Captured I/Q equal the direct-form FIR result for 1000 samples.
